// File: rtl/can_error_frame_tx.sv
// CAN error-frame transmitter: drives error flag, waits for recessive bus, then sends the delimiter.
// Optional passive error flag support is compiled in with `define CAN_ERROR_PASSIVE_EN.
module can_error_frame_tx #(
    parameter int unsigned FLAG_LEN  = 6,
    parameter int unsigned DELIM_LEN = 8,
    parameter int unsigned DOM_LIMIT = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic SP,
    input  logic RX,
    input  logic STF_E,
    input  logic EOF_E,
    input  logic CRC_E,
    input  logic FRM_E,
`ifdef CAN_ERROR_PASSIVE_EN
    input  logic PASSIVE,
`endif
    output logic TX,
    output logic BUSY,
    output logic DONE,
    output logic STUCK_DOM
);

    typedef enum logic [1:0] {S_IDLE, S_FLAG, S_WAIT_REC, S_DELIM} state_t;

    localparam logic [3:0] FLAG_LEN_C  = 4'(FLAG_LEN);
    localparam logic [3:0] DELIM_LEN_C = 4'(DELIM_LEN);
    localparam logic [3:0] DOM_LIMIT_C = 4'(DOM_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [3:0] domcnt_q, domcnt_d;
    logic       pending_q, pending_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       stuck_q, stuck_d;
    logic       err_any;
    logic       enter_flag;
`ifdef CAN_ERROR_PASSIVE_EN
    logic       passive_q, passive_d;
    logic       rx_last_q, rx_last_d;
    logic [3:0] eq_next;
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == '1) ? v : v + 4'd1;
    endfunction

    assign err_any = ~(STF_E & EOF_E & CRC_E & FRM_E);

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        domcnt_d   = domcnt_q;
        pending_d  = pending_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        stuck_d    = 1'b0;
        enter_flag = 1'b0;
`ifdef CAN_ERROR_PASSIVE_EN
        passive_d  = passive_q;
        rx_last_d  = rx_last_q;
        eq_next    = '0;
`endif
        if (state_q == S_IDLE && err_any) begin
            pending_d = 1'b1;
        end
        if (SP) begin
            case (state_q)
                S_IDLE: begin
                    if (pending_q || err_any) begin
                        enter_flag = 1'b1;
                    end
                end
                S_FLAG: begin
`ifdef CAN_ERROR_PASSIVE_EN
                    if (passive_q) begin
                        // bitcnt holds the run length of equal RX samples (0 = no sample yet)
                        eq_next   = (bitcnt_q != '0 && RX == rx_last_q) ? sat_inc(bitcnt_q) : 4'd1;
                        rx_last_d = RX;
                        if (eq_next == FLAG_LEN_C) begin
                            state_d  = S_WAIT_REC;
                            tx_d     = 1'b1;
                            domcnt_d = '0;
                        end else begin
                            bitcnt_d = eq_next;
                        end
                    end else
`endif
                    if (bitcnt_q == FLAG_LEN_C) begin
                        state_d  = S_WAIT_REC;
                        tx_d     = 1'b1;
                        domcnt_d = '0;
                    end else begin
                        bitcnt_d = sat_inc(bitcnt_q);
                    end
                end
                S_WAIT_REC: begin
                    if (RX) begin
                        state_d  = S_DELIM;
                        bitcnt_d = 4'd1;
                    end else if (sat_inc(domcnt_q) == DOM_LIMIT_C) begin
                        stuck_d  = 1'b1;
                        domcnt_d = '0;
                    end else begin
                        domcnt_d = sat_inc(domcnt_q);
                    end
                end
                S_DELIM: begin
                    if (!RX) begin
                        enter_flag = 1'b1;
                    end else if (bitcnt_q == DELIM_LEN_C) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bitcnt_d = sat_inc(bitcnt_q);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (enter_flag) begin
            state_d   = S_FLAG;
            busy_d    = 1'b1;
            pending_d = 1'b0;
            bitcnt_d  = 4'd1;
            tx_d      = 1'b0;
`ifdef CAN_ERROR_PASSIVE_EN
            passive_d = PASSIVE;
            if (PASSIVE) begin
                tx_d     = 1'b1;
                bitcnt_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            domcnt_q  <= '0;
            pending_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stuck_q   <= 1'b0;
`ifdef CAN_ERROR_PASSIVE_EN
            passive_q <= 1'b0;
            rx_last_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            domcnt_q  <= domcnt_d;
            pending_q <= pending_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            stuck_q   <= stuck_d;
`ifdef CAN_ERROR_PASSIVE_EN
            passive_q <= passive_d;
            rx_last_q <= rx_last_d;
`endif
        end
    end

    assign TX        = tx_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign STUCK_DOM = stuck_q;

endmodule

// File: tb/tb_can_error_frame_tx.sv
// Directed bench for can_error_frame_tx: expected outputs are queued per bit tick and checked after the edge.
module tb_can_error_frame_tx;

    logic clk = 1'b0;
    logic reset, SP, RX, STF_E, EOF_E, CRC_E, FRM_E;
    logic TX, BUSY, DONE, STUCK_DOM;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic tx;
        logic busy;
        logic done;
        logic stuck;
    } exp_t;

    exp_t exp_q[$];

    can_error_frame_tx #(.FLAG_LEN(6), .DELIM_LEN(8), .DOM_LIMIT(14)) dut (
        .clk(clk), .reset(reset), .SP(SP), .RX(RX),
        .STF_E(STF_E), .EOF_E(EOF_E), .CRC_E(CRC_E), .FRM_E(FRM_E),
        .TX(TX), .BUSY(BUSY), .DONE(DONE), .STUCK_DOM(STUCK_DOM)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic tx, input logic busy, input logic done, input logic stuck);
        exp_t e;
        e.tx = tx; e.busy = busy; e.done = done; e.stuck = stuck;
        exp_q.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_bit({tag, ".TX"}, TX, e.tx);
            check_bit({tag, ".BUSY"}, BUSY, e.busy);
            check_bit({tag, ".DONE"}, DONE, e.done);
            check_bit({tag, ".STUCK"}, STUCK_DOM, e.stuck);
        end
    endtask

    // One bit tick: drive RX with SP high across a rising edge, then check outputs and pulse clearing.
    task automatic tick(input logic rx, input logic tx, input logic busy, input logic done,
                        input logic stuck, input string tag);
        @(negedge clk);
        RX = rx;
        SP = 1'b1;
        push_exp(tx, busy, done, stuck);
        @(posedge clk);
        #1;
        SP = 1'b0;
        STF_E = 1'b1; EOF_E = 1'b1; CRC_E = 1'b1; FRM_E = 1'b1;
        pop_compare(tag);
        @(posedge clk);
        #1;
        check_bit({tag, ".pulse_clear"}, DONE | STUCK_DOM, 1'b0);
    endtask

    task automatic flag_rest(input int unsigned n_low, input string tag);
        for (int unsigned i = 0; i < n_low; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {tag, ".flag"});
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {tag, ".flag_exit"});
    endtask

    task automatic delim_done(input string tag);
        for (int unsigned i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {tag, ".delim"});
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, {tag, ".done"});
    endtask

    task automatic idle_ticks(input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset = 1'b0; SP = 1'b0; RX = 1'b1;
        STF_E = 1'b1; EOF_E = 1'b1; CRC_E = 1'b1; FRM_E = 1'b1;
        #12;
        push_exp(1'b1, 1'b0, 1'b0, 1'b0);
        pop_compare("reset_state");
        @(negedge clk);
        reset = 1'b1;
        idle_ticks(3, "idle");

        // stuff error pulse between ticks is remembered until the next tick
        @(negedge clk); STF_E = 1'b0;
        @(negedge clk); STF_E = 1'b1;
        check_bit("stf_pending_no_tick.TX", TX, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "stf.start");
        flag_rest(5, "stf");
        delim_done("stf");
        idle_ticks(2, "stf.after");

        // CRC error on the tick edge itself
        CRC_E = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "crc.start");
        flag_rest(5, "crc");
        delim_done("crc");
        idle_ticks(2, "crc.after");

        // superposition: 3 dominant bits after the flag
        FRM_E = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "sup.start");
        flag_rest(5, "sup");
        for (int unsigned i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "sup.dom");
        delim_done("sup");

        // stuck dominant: pulses on dominant ticks 14 and 28
        EOF_E = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "stuck.start");
        flag_rest(5, "stuck");
        for (int unsigned i = 1; i <= 30; i++)
            tick(1'b0, 1'b1, 1'b1, 1'b0, (i == 14 || i == 28), "stuck.dom");
        delim_done("stuck");

        // dominant at delimiter bit 5 restarts the flag without DONE
        STF_E = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "redo.start");
        flag_rest(5, "redo");
        for (int unsigned i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "redo.delim");
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "redo.restart");
        flag_rest(5, "redo2");
        delim_done("redo2");

        // asynchronous reset during flag bit 3
        EOF_E = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst.start");
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst.flag2");
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst.flag3");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        push_exp(1'b1, 1'b0, 1'b0, 1'b0);
        pop_compare("rst.async");
        @(negedge clk);
        reset = 1'b1;
        idle_ticks(4, "rst.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
